// File: rtl/video_pkg.sv
// Shared types and constants for the line-fetch display path.
// Fill FSM encoding, debug view and a constant-friendly clog2 helper.
package video_pkg;

  localparam int PIX_W = 24;
  localparam logic [23:0] BORDER_COLOR_DEF   = 24'h000000;
  localparam logic [23:0] UNDERRUN_COLOR_DEF = 24'hFF00FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } fill_state_e;

  // Observable controller state for checkers bound to the top.
  typedef struct packed {
    fill_state_e state;
    logic [1:0]  bank_ready;
    logic        fill_bank;
    logic        disp_bank;
  } fetch_dbg_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/line_buffer_2bank.sv
// Two-bank line store: one write port, one read port with a 1-cycle
// registered read. Contents are not reset; readers gate stale data.
module line_buffer_2bank
  import video_pkg::*;
#(
  parameter int DEPTH = 480,
  parameter int WIDTH = 24,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_bank,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [2][DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_bank][rd_addr];
  end

endmodule

// File: rtl/video_line_fetch.sv
// Prefetches rd-window lines into a ping-pong buffer and emits RGB aligned
// with sync/enable delayed by two clocks.
//
// Handshake: req_valid rises in REQ and stays high with req_line stable until
// req_ready is seen; the request transfers on req_valid & req_ready. The fill
// stream has no backpressure: wr_valid words are taken only while filling.
module video_line_fetch
  import video_pkg::*;
#(
  parameter int               RD_H           = 480,
  parameter int               RD_V           = 272,
  parameter int               PIX_W          = video_pkg::PIX_W,
  parameter logic [PIX_W-1:0] BORDER_COLOR   = BORDER_COLOR_DEF,
  parameter logic [PIX_W-1:0] UNDERRUN_COLOR = UNDERRUN_COLOR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic             de_in,
  input  logic             rd_in,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [8:0]       req_line,
  input  logic             wr_valid,
  input  logic [PIX_W-1:0] wr_data,
  output logic             hs_out,
  output logic             vs_out,
  output logic             de_out,
  output logic [PIX_W-1:0] rgb_out,
  output logic             underrun,
  output fetch_dbg_t       dbg
);

  localparam int              AW       = (RD_H > 1) ? clog2(RD_H) : 1;
  localparam logic [AW-1:0]   X_LAST   = AW'(RD_H - 1);
  localparam logic [8:0]      LINE_END = 9'(RD_V);

  fill_state_e      state;
  logic [1:0]       bank_ready;
  logic [1:0]       bank_ready_next;
  logic             fill_bank;
  logic             disp_bank;
  logic [8:0]       fill_line;
  logic [8:0]       disp_line;
  logic [AW-1:0]    wcnt;
  logic [AW-1:0]    xcnt;
  logic [AW-1:0]    rd_addr;
  logic             vs_prev;
  logic             rd_prev;
  logic             vs_rise;
  logic             rd_rise;
  logic             rd_fall;
  logic             fill_we;
  logic             fill_last;
  logic             line_ok;
  logic             line_ok_now;
  logic             hs_d1;
  logic             vs_d1;
  logic             de_d1;
  logic             rd_d1;
  logic [PIX_W-1:0] ram_q;
  logic [PIX_W-1:0] pixel_mux;

  assign vs_rise     = vs_in & ~vs_prev;
  assign rd_rise     = rd_in & ~rd_prev;
  assign rd_fall     = ~rd_in & rd_prev;
  assign fill_we     = (state == FILL) & wr_valid & ~vs_rise;
  assign fill_last   = fill_we & (wcnt == X_LAST);
  // The first pixel of a line is read in the same cycle rd_in rises.
  assign rd_addr     = rd_rise ? '0 : xcnt;
  assign line_ok_now = bank_ready[disp_bank] & (disp_line < LINE_END);

  assign req_valid = (state == REQ);
  assign req_line  = fill_line;
  assign dbg       = {state, bank_ready, fill_bank, disp_bank};

  // DONE and rd_in fall always target different banks, so both apply.
  always_comb begin
    bank_ready_next = bank_ready;
    if (state == DONE) begin
      bank_ready_next[fill_bank] = 1'b1;
    end
    if (rd_fall) begin
      bank_ready_next[disp_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fill_line <= '0;
      fill_bank <= 1'b0;
      wcnt      <= '0;
    end else if (vs_rise) begin
      state     <= REQ;
      fill_line <= '0;
      fill_bank <= 1'b0;
      wcnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bank_ready[fill_bank] && (fill_line < LINE_END)) begin
            state <= REQ;
          end
        end
        REQ: begin
          wcnt <= '0;
          if (req_ready) begin
            state <= FILL;
          end
        end
        FILL: begin
          if (fill_we) begin
            wcnt <= fill_last ? '0 : wcnt + 1'b1;
            if (fill_last) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          fill_bank <= ~fill_bank;
          if (fill_line < LINE_END) begin
            fill_line <= fill_line + 9'd1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev    <= 1'b0;
      rd_prev    <= 1'b0;
      bank_ready <= 2'b00;
      disp_line  <= '0;
      disp_bank  <= 1'b0;
      xcnt       <= '0;
      line_ok    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      vs_prev <= vs_in;
      rd_prev <= rd_in;
      if (vs_rise) begin
        bank_ready <= 2'b00;
        disp_line  <= '0;
        disp_bank  <= 1'b0;
        xcnt       <= '0;
        line_ok    <= 1'b0;
        underrun   <= 1'b0;
      end else begin
        bank_ready <= bank_ready_next;
        if (rd_in) begin
          xcnt <= (rd_addr == X_LAST) ? X_LAST : rd_addr + 1'b1;
        end
        if (rd_rise) begin
          line_ok <= line_ok_now;
          if (!line_ok_now) begin
            underrun <= 1'b1;
          end
        end
        if (rd_fall) begin
          disp_bank <= ~disp_bank;
          if (disp_line < LINE_END) begin
            disp_line <= disp_line + 9'd1;
          end
        end
      end
    end
  end

  line_buffer_2bank #(
    .DEPTH (RD_H),
    .WIDTH (PIX_W),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (fill_we),
    .wr_bank (fill_bank),
    .wr_addr (wcnt),
    .wr_data (wr_data),
    .rd_bank (disp_bank),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  always_comb begin
    pixel_mux = '0;
    if (!de_d1) begin
      pixel_mux = '0;
    end else if (!rd_d1) begin
      pixel_mux = BORDER_COLOR;
    end else if (line_ok) begin
      pixel_mux = ram_q;
    end else begin
      pixel_mux = UNDERRUN_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_d1   <= 1'b0;
      vs_d1   <= 1'b0;
      de_d1   <= 1'b0;
      rd_d1   <= 1'b0;
      hs_out  <= 1'b0;
      vs_out  <= 1'b0;
      de_out  <= 1'b0;
      rgb_out <= '0;
    end else begin
      hs_d1   <= hs_in;
      vs_d1   <= vs_in;
      de_d1   <= de_in;
      rd_d1   <= rd_in;
      hs_out  <= hs_d1;
      vs_out  <= vs_d1;
      de_out  <= de_d1;
      rgb_out <= pixel_mux;
    end
  end

endmodule
